lfsr_r24_checker: RTL and testbench

//  Self-synchronising receive-side checker for the 24-bit parallel PRBS produced by lfsr_R24.

---
 rtl/lfsr_r24_checker.sv | 172 +++++++++++++++++
 tb/tb_lfsr_r24_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_r24_checker.sv
// Self-synchronising checker for the 24-bit parallel PRBS stream: acquires lock, counts errors while locked.
// Latency: outputs are registered and reflect a valid word one cycle after it is sampled.
// Backpressure: none; a word is consumed on every cycle din_valid_i is high.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous reset, active low
//   clr_i            synchronous clear of both error counters (overrides increments)
//   din_i            received PRBS word, sampled when din_valid_i is high
//   din_valid_i      qualifies din_i
//   locked_o         checker is in the LOCKED state
//   err_o            one-cycle pulse: a bad word was counted while locked
//   word_err_cnt_o   saturating count of bad words seen while locked
//   bit_err_cnt_o    saturating sum of mismatched bits seen while locked
module lfsr_r24_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_CNT_W  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic [23:0]          din_i,
  input  logic                 din_valid_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] word_err_cnt_o,
  output logic [ERR_CNT_W-1:0] bit_err_cnt_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  // Next parallel PRBS word given the previous one.
  function automatic logic [23:0] prbs_next(input logic [23:0] l);
    logic [23:0] n;
    n    = '0;
    n[0] = l[10] ^ l[17] ^ l[20] ^ l[23] ^ l[0];
    n[1] = l[11] ^ l[17] ^ l[18] ^ l[21] ^ l[22] ^ l[23] ^ l[0] ^ l[1];
    for (int i = 2; i <= 6; i++) begin
      n[i] = l[i+10] ^ l[i+15] ^ l[i+16] ^ l[i+17] ^ l[i-2] ^ l[i-1] ^ l[i];
    end
    for (int i = 7; i <= 23; i++) begin
      n[i] = l[i-7] ^ l[i-2] ^ l[i-1] ^ l[i];
    end
    return n;
  endfunction

  function automatic logic [4:0] popcount24(input logic [23:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 24; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  state_t                state_q, state_d;
  logic [GW-1:0]         good_run_q, good_run_d;
  logic [BW-1:0]         bad_run_q, bad_run_d;
  logic [23:0]           prev_q;
  logic                  have_prev_q;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [ERR_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  logic                  cmp;
  logic [23:0]           mism;
  logic                  bad;
  logic                  count_evt;
  logic [ERR_CNT_W:0]    bit_sum;

  // A word is only compared once a predecessor exists; an all-zero word is
  // always bad so the checker can never lock onto the stuck-at-zero state.
  assign cmp  = din_valid_i & have_prev_q;
  assign mism = din_i ^ prbs_next(prev_q);
  assign bad  = (|mism) | (din_i == 24'd0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= SEARCH;
      good_run_q <= '0;
      bad_run_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    if (cmp) begin
      case (state_q)
        SEARCH: begin
          if (bad) begin
            good_run_d = '0;
          end else if (good_run_q == GW'(LOCK_CNT - 1)) begin
            state_d    = LOCKED;
            good_run_d = '0;
            bad_run_d  = '0;
          end else begin
            good_run_d = good_run_q + GW'(1);
          end
        end
        LOCKED: begin
          if (!bad) begin
            bad_run_d = '0;
          end else if (bad_run_q == BW'(UNLOCK_CNT - 1)) begin
            state_d    = SEARCH;
            good_run_d = '0;
            bad_run_d  = '0;
          end else begin
            bad_run_d = bad_run_q + BW'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Output / counter logic. The unlocking word is still counted because the
  // decision uses the current (LOCKED) state.
  always_comb begin
    count_evt  = cmp & bad & (state_q == LOCKED);
    err_d      = count_evt;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_sum    = {1'b0, bit_cnt_q} + {{(ERR_CNT_W-4){1'b0}}, popcount24(mism)};
    if (count_evt) begin
      if (!(&word_cnt_q)) begin
        word_cnt_d = word_cnt_q + ERR_CNT_W'(1);
      end
      // Clamp to all-ones when the add carries out.
      bit_cnt_d = bit_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : bit_sum[ERR_CNT_W-1:0];
    end
    if (clr_i) begin
      word_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      bit_cnt_q   <= '0;
    end else begin
      if (din_valid_i) begin
        prev_q      <= din_i;
        have_prev_q <= 1'b1;
      end
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign locked_o       = (state_q == LOCKED);
  assign err_o          = err_q;
  assign word_err_cnt_o = word_cnt_q;
  assign bit_err_cnt_o  = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_r24_checker.sv
module tb_lfsr_r24_checker;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [23:0] din;
  logic        vld;

  logic        locked32, err32, locked5, err5;
  logic [31:0] wc32, bc32;
  logic [4:0]  wc5, bc5;

  int checks = 0;
  int errors = 0;
  bit run    = 0;

  lfsr_r24_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .din_i(din), .din_valid_i(vld),
    .locked_o(locked32), .err_o(err32), .word_err_cnt_o(wc32), .bit_err_cnt_o(bc32)
  );

  lfsr_r24_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_CNT_W(5)) dut5 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .din_i(din), .din_valid_i(vld),
    .locked_o(locked5), .err_o(err5), .word_err_cnt_o(wc5), .bit_err_cnt_o(bc5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [23:0] m_prev;
  bit          m_have, m_locked, m_err;
  int          m_good, m_bad;
  longint      m_wc32, m_bc32, m_wc5, m_bc5;

  function automatic logic [23:0] succ(input logic [23:0] l);
    logic [23:0] n;
    n    = '0;
    n[0] = l[10] ^ l[17] ^ l[20] ^ l[23] ^ l[0];
    n[1] = l[11] ^ l[17] ^ l[18] ^ l[21] ^ l[22] ^ l[23] ^ l[0] ^ l[1];
    for (int i = 2; i <= 6; i++) n[i] = l[i+10] ^ l[i+15] ^ l[i+16] ^ l[i+17] ^ l[i-2] ^ l[i-1] ^ l[i];
    for (int i = 7; i <= 23; i++) n[i] = l[i-7] ^ l[i-2] ^ l[i-1] ^ l[i];
    return n;
  endfunction

  function automatic longint satadd(input longint a, input longint b, input int w);
    longint mx;
    mx = (64'd1 << w) - 1;
    return (a + b > mx) ? mx : a + b;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_have = 0; m_locked = 0; m_err = 0;
    m_good = 0; m_bad = 0;
    m_wc32 = 0; m_bc32 = 0; m_wc5 = 0; m_bc5 = 0;
  endtask

  task automatic model_step(input bit v, input logic [23:0] d, input bit c);
    logic [23:0] mism;
    bit          bad;
    m_err = 0;
    if (v) begin
      if (m_have) begin
        mism = d ^ succ(m_prev);
        bad  = (mism != 0) || (d == 0);
        if (!m_locked) begin
          if (bad) m_good = 0;
          else begin
            m_good++;
            if (m_good == 16) begin m_locked = 1; m_bad = 0; end
          end
        end else if (bad) begin
          m_err  = 1;
          m_wc32 = satadd(m_wc32, 1, 32);
          m_bc32 = satadd(m_bc32, $countones(mism), 32);
          m_wc5  = satadd(m_wc5, 1, 5);
          m_bc5  = satadd(m_bc5, $countones(mism), 5);
          m_bad++;
          if (m_bad == 4) begin m_locked = 0; m_good = 0; end
        end else begin
          m_bad = 0;
        end
      end
      m_prev = d;
      m_have = 1;
    end
    if (c) begin
      m_wc32 = 0; m_bc32 = 0; m_wc5 = 0; m_bc5 = 0;
    end
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #2;
    if (run) begin
      chk("locked32", longint'(locked32), longint'(m_locked));
      chk("err32",    longint'(err32),    longint'(m_err));
      chk("wc32",     longint'(wc32),     m_wc32);
      chk("bc32",     longint'(bc32),     m_bc32);
      chk("locked5",  longint'(locked5),  longint'(m_locked));
      chk("err5",     longint'(err5),     longint'(m_err));
      chk("wc5",      longint'(wc5),      m_wc5);
      chk("bc5",      longint'(bc5),      m_bc5);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [23:0] g;

  task automatic next_prbs(output logic [23:0] w);
    w = g;
    g = succ(g);
  endtask

  task automatic drive(input bit v, input logic [23:0] d, input bit c);
    @(negedge clk);
    vld = v; din = d; clr = c;
    model_step(v, d, c);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vld = 1'b0; clr = 1'b0; din = '0;
    model_reset();
    #1;
    chk("rst_locked", longint'(locked32), 0);
    chk("rst_err",    longint'(err32),    0);
    chk("rst_wc",     longint'(wc32),     0);
    chk("rst_bc",     longint'(bc32),     0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lock_stream(input bit toggle);
    logic [23:0] w;
    g = 24'h4DB62E;
    for (int k = 0; k <= 16; k++) begin
      next_prbs(w);
      drive(1, w, 0);
      if (k == 15) begin after_edge(); chk("not_yet_locked", longint'(locked32), 0); end
      if (k == 16) begin after_edge(); chk("locked_after_16", longint'(locked32), 1); end
      if (toggle && k != 16) drive(0, 24'($urandom), 0);
    end
  endtask

  initial begin
    logic [23:0] w, junk;
    rst_n = 1'b0; vld = 1'b0; clr = 1'b0; din = '0;
    model_reset();
    do_reset();
    run = 1;

    // 1: acquire lock on a clean stream
    lock_stream(0);
    chk("t1_wc", longint'(wc32), 0);
    chk("t1_bc", longint'(bc32), 0);

    // 2: single-bit flip on DIN[0] -> two bad words, 1 + 4 bits
    for (int k = 0; k < 3; k++) begin next_prbs(w); drive(1, w, 0); end
    next_prbs(w); drive(1, w ^ 24'h000001, 0);
    after_edge(); chk("t2_err_a", longint'(err32), 1);
    next_prbs(w); drive(1, w, 0);
    after_edge(); chk("t2_err_b", longint'(err32), 1);
    next_prbs(w); drive(1, w, 0);
    after_edge(); chk("t2_err_c", longint'(err32), 0);
    chk("t2_wc", longint'(wc32), 2);
    chk("t2_bc", longint'(bc32), 5);
    chk("t2_locked", longint'(locked32), 1);

    // 3: four non-PRBS words drop lock, then relock
    junk = w;
    for (int k = 0; k < 4; k++) begin
      junk = succ(junk) ^ 24'hA5A5A5;
      drive(1, junk, 0);
    end
    after_edge(); chk("t3_unlocked", longint'(locked32), 0);
    chk("t3_wc", longint'(wc32), 6);
    for (int k = 0; k < 17; k++) begin
      next_prbs(w); drive(1, w, 0);
      if (k == 15) begin after_edge(); chk("t3_not_relocked", longint'(locked32), 0); end
    end
    after_edge(); chk("t3_relocked", longint'(locked32), 1);
    chk("t3_wc_kept", longint'(wc32), 6);

    // 4: all-zero words never lock
    do_reset();
    for (int k = 0; k < 32; k++) drive(1, 24'd0, 0);
    after_edge();
    chk("t4_locked", longint'(locked32), 0);
    chk("t4_wc", longint'(wc32), 0);
    chk("t4_bc", longint'(bc32), 0);

    // 5: valid toggling every cycle
    do_reset();
    lock_stream(1);

    // 6: saturation on the 5-bit instance, CLR vs increment, reset mid-lock
    for (int k = 0; k < 20; k++) begin
      next_prbs(w); drive(1, w ^ (24'd1 << $urandom_range(23, 0)), 0);
      next_prbs(w); drive(1, w, 0);
      next_prbs(w); drive(1, w, 0);
    end
    after_edge();
    chk("t6_wc5_sat", longint'(wc5), 31);
    chk("t6_bc5_sat", longint'(bc5), 31);
    chk("t6_locked", longint'(locked5), 1);
    next_prbs(w); drive(1, w ^ 24'h000001, 1);
    after_edge();
    chk("t6_clr_wc5", longint'(wc5), 0);
    chk("t6_clr_wc32", longint'(wc32), 0);
    chk("t6_clr_err", longint'(err32), 1);
    next_prbs(w); drive(1, w, 0);
    next_prbs(w); drive(1, w, 0);
    do_reset();

    // Randomised phase
    g = 24'h4DB62E;
    for (int n = 0; n < 3000; n++) begin
      bit v, c;
      v = ($urandom_range(99, 0) < 75);
      c = ($urandom_range(199, 0) == 0);
      w = 24'($urandom);
      if (v) begin
        int r;
        r = $urandom_range(99, 0);
        next_prbs(w);
        if (r < 5) w = w ^ (24'd1 << $urandom_range(23, 0));
        else if (r < 7) w = 24'($urandom);
        else if (r == 7) w = 24'd0;
        else if (r == 8) begin g = 24'($urandom) | 24'd1; end
      end
      drive(v, w, c);
    end
    drive(0, 24'd0, 0);
    drive(0, 24'd0, 0);
    after_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
